// File: rtl/contador_bcd_pkg.sv
// contador_bcd_pkg: shared BCD digit type, limits and direction encoding
package contador_bcd_pkg;
  typedef logic [3:0] bcd_digit_t;
  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;
  localparam int NUM_DIGITS = 4;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one decade register, steps up/down with wrap; illegal values recover to 0
module bcd_digit
  import contador_bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic       i_dir,
  input  logic       i_hold,
  output bcd_digit_t o_digit,
  output logic       o_is_max,
  output logic       o_is_min
);
  bcd_digit_t r_digit, w_next;
  always_comb
    w_next = (r_digit > BCD_MAX) ? BCD_MIN :
             (i_dir == DIR_DOWN) ? ((r_digit == BCD_MIN) ? BCD_MAX : r_digit - 4'd1) :
                                   ((r_digit == BCD_MAX) ? BCD_MIN : r_digit + 4'd1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_digit <= BCD_MIN;
    else if (i_en && !i_hold) r_digit <= w_next;
  assign o_digit  = r_digit;
  assign o_is_max = (r_digit == BCD_MAX);
  assign o_is_min = (r_digit == BCD_MIN);
endmodule

// File: rtl/contador_bcd.sv
// contador_bcd: four-decade BCD up/down counter, 0000-9999.
// CONTADOR_BCD_SAT_EN makes it saturate at 9999/0000 instead of wrapping.
module contador_bcd
  import contador_bcd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic [0:0]  sel,
  output logic [11:0] sal,
  output logic [3:0]  sal_aux
);
`ifdef CONTADOR_BCD_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif
  bcd_digit_t w_dig [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_max, w_min, w_en;
  logic [NUM_DIGITS:0] w_c;
  logic w_hold;
  assign w_c[0] = 1'b1;
  // w_c[NUM_DIGITS] marks the whole counter sitting at the limit in the current direction
  assign w_hold = SAT & w_c[NUM_DIGITS];
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    assign w_c[i+1] = w_c[i] & ((sel == DIR_UP) ? w_max[i] : w_min[i]);
    // a corrupted digit is neither max nor min, so it self-clears without rippling
    assign w_en[i] = clk_en & (w_c[i] | (w_dig[i] > BCD_MAX));
    bcd_digit u_digit (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_en[i]),
      .i_dir   (sel[0]),
      .i_hold  (w_hold),
      .o_digit (w_dig[i]),
      .o_is_max(w_max[i]),
      .o_is_min(w_min[i])
    );
  end
  assign sal     = {w_dig[2], w_dig[1], w_dig[0]};
  assign sal_aux = w_dig[3];
endmodule

// File: tb/tb_contador_bcd.sv
// tb_contador_bcd: random and directed stimulus against an integer-valued reference counter
module tb_contador_bcd;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clk_en = 1'b0;
  logic [0:0]  sel = 1'b0;
  logic [11:0] sal;
  logic [3:0]  sal_aux;
  int errs = 0;
  int checks = 0;
  int m = 0;
`ifdef CONTADOR_BCD_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  contador_bcd dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .sel    (sel),
    .sal    (sal),
    .sal_aux(sal_aux)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] bcd(int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int nxt(int v, logic dir);
    if (SAT && !dir && v == 9999) return 9999;
    if (SAT && dir && v == 0) return 0;
    return dir ? (v + 9999) % 10000 : (v + 1) % 10000;
  endfunction

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(logic en, logic dir, string tag);
    @(negedge clk);
    clk_en = en;
    sel = dir;
    @(posedge clk);
    if (en) m = nxt(m, dir);
    #1 chk(tag, {sal_aux, sal}, bcd(m));
  endtask

  task automatic goto(int t);
    while (m != t) step(1'b1, m > t, "goto");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clk_en = 1'b0;
    m = 0;
    #1 chk("rst_clear", {sal_aux, sal}, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int bad;
    logic [15:0] v;
    repeat (3) @(posedge clk);
    #1 chk("rst_init", {sal_aux, sal}, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) step(1'b0, 1'b0, "gate_off");
    chk("gate_off_0000", {sal_aux, sal}, 16'h0000);
    repeat (10) step(1'b1, 1'b0, "gate_on");
    chk("gate_on_0010", {sal_aux, sal}, 16'h0010);
    goto(99);
    step(1'b1, 1'b0, "up_99");
    chk("carry_0100", {sal_aux, sal}, 16'h0100);
    goto(999);
    step(1'b1, 1'b0, "up_999");
    chk("carry_1000", {sal_aux, sal}, 16'h1000);
    goto(9999);
    step(1'b1, 1'b0, "up_9999");
    chk("top_limit", {sal_aux, sal}, SAT ? 16'h9999 : 16'h0000);
    step(1'b1, 1'b1, "reverse_dn");
    goto(1000);
    step(1'b1, 1'b1, "dn_1000");
    chk("borrow_0999", {sal_aux, sal}, 16'h0999);
    goto(0);
    step(1'b1, 1'b1, "dn_0000");
    chk("bottom_limit", {sal_aux, sal}, SAT ? 16'h0000 : 16'h9999);
    step(1'b1, 1'b0, "reverse_up");
    goto(5);
    repeat (3) step(1'b1, 1'b1, "toggle_dn");
    chk("toggle_0002", {sal_aux, sal}, 16'h0002);
    step(1'b1, 1'b0, "toggle_up");
    chk("toggle_0003", {sal_aux, sal}, 16'h0003);
    goto(123);
    // async reset mid-cycle with counting still enabled
    @(negedge clk);
    clk_en = 1'b1;
    sel = 1'b0;
    @(posedge clk);
    m = nxt(m, 1'b0);
    #2 rst = 1'b0;
    m = 0;
    #1 chk("rst_async", {sal_aux, sal}, 16'h0000);
    repeat (3) begin
      @(posedge clk);
      #1 chk("rst_held", {sal_aux, sal}, 16'h0000);
    end
    @(negedge clk);
    rst = 1'b1;
    clk_en = 1'b0;
    repeat (400) step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), "random");
    do_reset();
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      step(1'b1, 1'b0, "exhaustive");
      v = {sal_aux, sal};
      for (int d = 0; d < 4; d++) if (v[d*4 +: 4] > 4'd9) bad++;
    end
    chk("nibble_legal", 16'(bad), 16'h0000);
    chk("wrap_10000", {sal_aux, sal}, SAT ? 16'h9999 : 16'h0000);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
